// File: rtl/tm1638_arb_pkg.sv
// rtl/tm1638_arb_pkg.sv - shared types, constants and helpers for the TM1638 panel arbiter
package tm1638_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  localparam int US_PER_MS = 1000;

  // Counter width able to hold 0..n-1 (never narrower than one bit).
  function automatic int cw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int cycles_per_ms(input int clk_mhz);
    return clk_mhz * US_PER_MS;
  endfunction

  // Client frames are abcdefgh (a at bit 7); the board controller wants hgfedcba.
  function automatic logic [7:0] swap8(input logic [7:0] abcdefgh);
    logic [7:0] v;
    for (int b = 0; b < 8; b++) begin
      v[b] = abcdefgh[7-b];
    end
    return v;
  endfunction

endpackage

// File: rtl/tm1638_rr_pick.sv
// rtl/tm1638_rr_pick.sv - combinational round-robin winner with optional requester-0 priority
module tm1638_rr_pick
  import tm1638_arb_pkg::*;
#(
  parameter int n_req = 4
) (
  input  logic [n_req-1:0]         i_mask,
  input  logic [$clog2(n_req)-1:0] i_start,
  input  logic                     i_prio,
  output logic                     o_any,
  output logic [$clog2(n_req)-1:0] o_win
);
  localparam int OW = $clog2(n_req);

  // Walk the ring backwards so the last hit is the one closest to i_start.
  always_comb begin
    o_any = |i_mask;
    o_win = '0;
    for (int k = n_req - 1; k >= 0; k--) begin
      if (i_mask[OW'((int'(i_start) + k) % n_req)]) begin
        o_win = OW'((int'(i_start) + k) % n_req);
      end
    end
    if (i_prio && i_mask[0]) begin
      o_win = '0;
    end
  end

endmodule

// File: rtl/tm1638_panel_arbiter.sv
// rtl/tm1638_panel_arbiter.sv - shares one TM1638 panel between n_req clients with dwell and blanking
// Optional feature macro: TM1638_ARB_PREEMPT_EN (requester 0 preempts other owners).
module tm1638_panel_arbiter
  import tm1638_arb_pkg::*;
#(
  parameter int clk_mhz  = 27,
  parameter int n_req    = 4,
  parameter int w_digit  = 8,
  parameter int w_led    = 8,
  parameter int w_key    = 8,
  parameter int dwell_ms = 500,
  parameter int scan_us  = 1000,
  parameter int blank_us = 2000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [n_req-1:0]             req_valid,
  output logic [n_req-1:0]             req_ready,
  input  logic [n_req*w_digit*8-1:0]   req_segs,
  input  logic [n_req*w_led-1:0]       req_leds,
  input  logic [w_key-1:0]             keys_in,
  output logic [n_req*w_key-1:0]       keys_out,
  output logic [$clog2(n_req)-1:0]     owner,
  output logic                         owner_vld,
  output logic [7:0]                   hgfedcba,
  output logic [w_digit-1:0]           digit,
  output logic [w_led-1:0]             ledr
);
  localparam int OW     = $clog2(n_req);
  localparam int FW     = w_digit * 8;
  localparam int US_W   = cw(clk_mhz);
  localparam int SCAN_W = cw(scan_us);
  localparam int BLK_W  = cw(blank_us);
  localparam int MS_W   = cw(US_PER_MS);
  localparam int DW_W   = cw(dwell_ms + 1);
  localparam int IDX_W  = cw(w_digit);

  state_t            r_state;
  logic [OW-1:0]     r_ptr;
  logic              r_first;
  logic [OW-1:0]     r_owner;
  logic              r_owner_vld;
  logic [FW-1:0]     r_frame;
  logic [w_led-1:0]  r_leds;
  logic [BLK_W-1:0]  r_blank;
  logic [MS_W-1:0]   r_ms_us;
  logic [DW_W-1:0]   r_dwell;
  logic [US_W-1:0]   r_us_cnt;
  logic [SCAN_W-1:0] r_scan_cnt;
  logic [IDX_W-1:0]  r_idx;

  logic              w_tick_us;
  logic              w_expired;
  logic [n_req-1:0]  w_own_oh;
  logic [n_req-1:0]  w_mask;
  logic              w_prio;
  logic [OW-1:0]     w_start;
  logic              w_any;
  logic [OW-1:0]     w_win;
  logic [OW-1:0]     w_src;
  logic [FW-1:0]     w_sel_segs;
  logic [w_led-1:0]  w_sel_leds;
  logic [7:0]        w_cur_seg;

  assign w_tick_us = (r_us_cnt == US_W'(clk_mhz - 1));
  assign w_expired = (r_dwell == DW_W'(dwell_ms));
  assign owner     = r_owner;
  assign owner_vld = r_owner_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_us_cnt   <= '0;
      r_scan_cnt <= '0;
      r_idx      <= '0;
    end else begin
      r_us_cnt <= w_tick_us ? '0 : r_us_cnt + 1'b1;
      if (w_tick_us) begin
        if (r_scan_cnt == SCAN_W'(scan_us - 1)) begin
          r_scan_cnt <= '0;
          r_idx      <= (r_idx == IDX_W'(w_digit - 1)) ? '0 : r_idx + 1'b1;
        end else begin
          r_scan_cnt <= r_scan_cnt + 1'b1;
        end
      end
    end
  end

  // Requests eligible for an arbitration event in the current state.
  always_comb begin
    w_own_oh = '0;
    for (int i = 0; i < n_req; i++) begin
      w_own_oh[i] = (OW'(i) == r_owner);
    end
    w_mask = '0;
    w_prio = 1'b0;
    case (r_state)
      IDLE:    w_mask = req_valid;
      SHOW:    w_mask = w_expired ? (req_valid & ~w_own_oh) : '0;
      default: w_mask = '0;
    endcase
`ifdef TM1638_ARB_PREEMPT_EN
    w_prio = 1'b1;
    if (r_state == SHOW && !w_expired && r_owner != '0) begin
      w_mask[0] = req_valid[0];
    end
`else
    w_prio = 1'b0;
`endif
    if (r_first) begin
      w_start = '0;
    end else begin
      w_start = (r_ptr == OW'(n_req - 1)) ? '0 : r_ptr + 1'b1;
    end
  end

  tm1638_rr_pick #(
    .n_req (n_req)
  ) u_pick (
    .i_mask  (w_mask),
    .i_start (w_start),
    .i_prio  (w_prio),
    .o_any   (w_any),
    .o_win   (w_win)
  );

  assign w_src = w_any ? w_win : r_owner;

  always_comb begin
    w_sel_segs = '0;
    w_sel_leds = '0;
    for (int i = 0; i < n_req; i++) begin
      if (OW'(i) == w_src) begin
        w_sel_segs = req_segs[i*FW +: FW];
        w_sel_leds = req_leds[i*w_led +: w_led];
      end
    end
  end

  // On a switch cycle only the winner is ready; the old owner's update is dropped.
  always_comb begin
    req_ready = '0;
    if (w_any) begin
      for (int i = 0; i < n_req; i++) begin
        req_ready[i] = (OW'(i) == w_win);
      end
    end else if (r_state == SHOW) begin
      for (int i = 0; i < n_req; i++) begin
        req_ready[i] = (OW'(i) == r_owner) && req_valid[i];
      end
    end
    if (rst) begin
      req_ready = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_first     <= 1'b1;
      r_owner     <= '0;
      r_owner_vld <= 1'b0;
      r_frame     <= '0;
      r_leds      <= '0;
      r_blank     <= '0;
      r_ms_us     <= '0;
      r_dwell     <= '0;
    end else if (w_any) begin
      r_state     <= BLANK;
      r_owner     <= w_win;
      r_ptr       <= w_win;
      r_first     <= 1'b0;
      r_owner_vld <= 1'b0;
      r_frame     <= w_sel_segs;
      r_leds      <= w_sel_leds;
      r_blank     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_owner_vld <= 1'b0;
        end
        BLANK: begin
          if (w_tick_us) begin
            if (r_blank == BLK_W'(blank_us - 1)) begin
              r_state     <= SHOW;
              r_owner_vld <= 1'b1;
              r_ms_us     <= '0;
              r_dwell     <= '0;
            end else begin
              r_blank <= r_blank + 1'b1;
            end
          end
        end
        SHOW: begin
          if (req_valid[r_owner]) begin
            r_frame <= w_sel_segs;
            r_leds  <= w_sel_leds;
          end
          if (w_tick_us && !w_expired) begin
            if (r_ms_us == MS_W'(US_PER_MS - 1)) begin
              r_ms_us <= '0;
              r_dwell <= r_dwell + 1'b1;
            end else begin
              r_ms_us <= r_ms_us + 1'b1;
            end
          end
        end
        default: begin
          r_state     <= IDLE;
          r_owner_vld <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    digit     = '0;
    hgfedcba  = '0;
    ledr      = '0;
    keys_out  = '0;
    w_cur_seg = '0;
    for (int d = 0; d < w_digit; d++) begin
      if (IDX_W'(d) == r_idx) begin
        w_cur_seg = r_frame[d*8 +: 8];
      end
    end
    if (r_owner_vld) begin
      for (int d = 0; d < w_digit; d++) begin
        digit[d] = (IDX_W'(d) == r_idx);
      end
      hgfedcba = swap8(w_cur_seg);
      ledr     = r_leds;
      for (int i = 0; i < n_req; i++) begin
        if (OW'(i) == r_owner) begin
          keys_out[i*w_key +: w_key] = keys_in;
        end
      end
    end
  end

endmodule

// File: tb/tb_tm1638_panel_arbiter.sv
// tb/tb_tm1638_panel_arbiter.sv - directed self-checking bench for tm1638_panel_arbiter
module tb_tm1638_panel_arbiter;
  logic         clk;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [255:0] req_segs;
  logic [31:0]  req_leds;
  logic [7:0]   keys_in;
  logic [31:0]  keys_out;
  logic [1:0]   owner;
  logic         owner_vld;
  logic [7:0]   hgfedcba;
  logic [7:0]   digit;
  logic [7:0]   ledr;

  int n_assert = 0;
  int n_fail   = 0;
  int n_clk    = 0;

  tm1638_panel_arbiter #(
    .clk_mhz  (1),
    .n_req    (4),
    .w_digit  (8),
    .w_led    (8),
    .w_key    (8),
    .dwell_ms (1),
    .scan_us  (2),
    .blank_us (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_segs  (req_segs),
    .req_leds  (req_leds),
    .keys_in   (keys_in),
    .keys_out  (keys_out),
    .owner     (owner),
    .owner_vld (owner_vld),
    .hgfedcba  (hgfedcba),
    .digit     (digit),
    .ledr      (ledr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rising edges since the last reset release.
  always @(posedge clk) begin
    if (rst) n_clk <= 0;
    else     n_clk <= n_clk + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_n(input int target);
    while (n_clk < target) @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_segs  = '0;
    req_leds  = '0;
    keys_in   = '0;
    repeat (3) @(negedge clk);
    check("rst_digit", {24'd0, digit}, 32'h0);
    check("rst_ledr", {24'd0, ledr}, 32'h0);
    check("rst_hgf", {24'd0, hgfedcba}, 32'h0);
    check("rst_owner", {30'd0, owner}, 32'h0);
    check("rst_vld", {31'd0, owner_vld}, 32'h0);
    check("rst_keys", keys_out, 32'h0);

    // Requester 2 alone after reset.
    req_segs[2*64 +: 8]     = 8'h80;
    req_segs[2*64 + 8 +: 8] = 8'h40;
    req_leds[2*8 +: 8]      = 8'hA5;
    req_valid = 4'b0100;
    rst       = 1'b0;
    #1;
    check("t1_ready_grant", {28'd0, req_ready}, 32'h4);
    wait_n(1);
    check("t1_ready_blank", {28'd0, req_ready}, 32'h0);
    check("t1_owner", {30'd0, owner}, 32'h2);
    check("t1_blank_digit", {24'd0, digit}, 32'h0);
    req_valid = '0;
    wait_n(4);
    check("t1_blank_end", {31'd0, owner_vld}, 32'h0);
    wait_n(5);
    check("t1_show", {31'd0, owner_vld}, 32'h1);
    check("t1_digit5", {24'd0, digit}, 32'h04);
    check("t1_ledr", {24'd0, ledr}, 32'hA5);
    wait_n(6);
    check("t1_digit6", {24'd0, digit}, 32'h08);
    wait_n(7);
    check("t1_digit7", {24'd0, digit}, 32'h08);
    wait_n(8);
    check("t1_digit8", {24'd0, digit}, 32'h10);

    // Live update from the owner.
    wait_n(10);
    req_leds[2*8 +: 8] = 8'h3C;
    req_valid = 4'b0100;
    #1;
    check("live_ready", {28'd0, req_ready}, 32'h4);
    wait_n(11);
    check("live_ledr", {24'd0, ledr}, 32'h3C);
    req_valid = '0;

    wait_n(16);
    check("t2_digit0", {24'd0, digit}, 32'h01);
    check("t2_seg_a", {24'd0, hgfedcba}, 32'h01);
    wait_n(18);
    check("t2_digit1", {24'd0, digit}, 32'h02);
    check("t2_seg_b", {24'd0, hgfedcba}, 32'h02);

    // Requesters 0 and 3 together, ptr = 2.
    wait_n(20);
    req_leds[3*8 +: 8] = 8'h33;
    req_leds[0 +: 8]   = 8'h0F;
    req_valid = 4'b1001;
    #1;
    check("t4_dwell_hold", {28'd0, req_ready}, 32'h0);
    wait_n(1004);
    check("t4_pre_expiry", {28'd0, req_ready}, 32'h0);
    wait_n(1005);
    check("t4_win3", {28'd0, req_ready}, 32'h8);
    wait_n(1006);
    check("t4_owner3", {30'd0, owner}, 32'h3);
    check("t4_blank", {31'd0, owner_vld}, 32'h0);
    wait_n(1010);
    check("t4_show3", {31'd0, owner_vld}, 32'h1);
    check("t4_ledr3", {24'd0, ledr}, 32'h33);
    check("t4_live3", {28'd0, req_ready}, 32'h8);
    wait_n(2009);
    check("t4_hold3", {28'd0, req_ready}, 32'h8);
    wait_n(2010);
    check("t4_win0", {28'd0, req_ready}, 32'h1);
    wait_n(2011);
    check("t4_owner0", {30'd0, owner}, 32'h0);
    req_valid = '0;
    wait_n(2015);
    check("t4_ledr0", {24'd0, ledr}, 32'h0F);

    // Move ownership to requester 1.
    wait_n(2016);
    req_leds[1*8 +: 8] = 8'h11;
    req_valid = 4'b0010;
    wait_n(3014);
    check("to1_hold", {28'd0, req_ready}, 32'h0);
    wait_n(3015);
    check("to1_win", {28'd0, req_ready}, 32'h2);
    wait_n(3016);
    req_valid = '0;
    wait_n(3020);
    check("to1_owner", {30'd0, owner}, 32'h1);
    check("to1_ledr", {24'd0, ledr}, 32'h11);

    // Requester 3 waits out the dwell of owner 1.
    wait_n(3120);
    req_valid = 4'b1000;
    wait_n(3121);
    check("t3_no_switch", {28'd0, req_ready}, 32'h0);
    check("t3_still_show", {31'd0, owner_vld}, 32'h1);
    wait_n(3200);
    keys_in = 8'h05;
    #1;
    check("t5_keys_owner1", keys_out, 32'h0000_0500);
    wait_n(4019);
    check("t3_last_hold", {28'd0, req_ready}, 32'h0);
    check("t3_owner1", {30'd0, owner}, 32'h1);
    wait_n(4020);
    check("t3_switch", {28'd0, req_ready}, 32'h8);
    wait_n(4021);
    check("t3_owner3", {30'd0, owner}, 32'h3);
    check("t3_blank", {31'd0, owner_vld}, 32'h0);
    check("t5_keys_blank", keys_out, 32'h0);
    check("t3_blank_digit", {24'd0, digit}, 32'h0);

    // Reset while showing.
    wait_n(4030);
    check("t6_pre_show", {31'd0, owner_vld}, 32'h1);
    rst = 1'b1;
    #1;
    check("t6_digit", {24'd0, digit}, 32'h0);
    check("t6_ledr", {24'd0, ledr}, 32'h0);
    check("t6_ready", {28'd0, req_ready}, 32'h0);
    check("t6_vld", {31'd0, owner_vld}, 32'h0);
    check("t6_keys", keys_out, 32'h0);
    repeat (2) @(negedge clk);
    req_valid = 4'b0110;
    rst       = 1'b0;
    #1;
    check("t6_first_from0", {28'd0, req_ready}, 32'h2);
    wait_n(1);
    req_valid = '0;
    check("t6_owner1", {30'd0, owner}, 32'h1);

    // Requester 0 inside the dwell of owner 1.
    wait_n(15);
    req_valid = 4'b0001;
    #1;
`ifdef TM1638_ARB_PREEMPT_EN
    check("pre_ready0", {28'd0, req_ready}, 32'h1);
    wait_n(16);
    check("pre_owner0", {30'd0, owner}, 32'h0);
    check("pre_blank", {31'd0, owner_vld}, 32'h0);
`else
    check("nopre_ready", {28'd0, req_ready}, 32'h0);
    wait_n(16);
    check("nopre_owner1", {30'd0, owner}, 32'h1);
    check("nopre_show", {31'd0, owner_vld}, 32'h1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
